nanorv32_divseq: RTL and testbench
==================================

// Module: nanorv32_divseq
// PURPOSE
//  Sequencer between the decode/execute stage and the iterative divider. Accepts DIV/DIVU/REM/REMU
//  ops, drives the divider request/response handshake and stalls the pipeline while busy.
//  Resolves divide-by-zero and signed overflow locally in 1 cycle. Caches the last quotient/remainder
//  pair so that a DIV followed by a REM on the same operands skips the divider.
//  Aborts cleanly on pipeline flush.
// PARAMETERS
//  DATA_W     32   operand/result width
//  CACHE_EN   1    1: quotient/remainder cache enabled; 0: every non-special op uses the divider
// PORTS
//  clk             in   1       core clock
//  rst_n           in   1       asynchronous active-low reset
//  op_valid        in   1       divide-class op present at execute; held stable while stall=1
//  op_signed       in   1       1: DIV/REM, 0: DIVU/REMU
//  op_rem          in   1       1: remainder result, 0: quotient result
//  op_a            in   DATA_W  dividend
//  op_b            in   DATA_W  divisor
//  flush           in   1       pipeline flush; kills the current op
//  stall           out  1       hold pipeline (combinational)
//  res_valid       out  1       1-cycle result strobe (registered)
//  res             out  DATA_W  result, valid when res_valid=1
//  div_req_valid   out  1       divider request
//  div_req_ready   in   1       divider accepts request
//  div_req_signed  out  1       signed divide
//  div_req_a       out  DATA_W  dividend to divider (registered)
//  div_req_b       out  DATA_W  divisor to divider (registered)
//  div_resp_valid  in   1       divider result strobe
//  div_resp_quo    in   DATA_W  quotient
//  div_resp_rem    in   DATA_W  remainder
// BEHAVIOUR
//  Reset: state=IDLE, cache_vld=0, res=0, res_valid=0, div_req_valid=0, div_req_a/b=0.
//  FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
//  IDLE: if op_valid & ~flush:
//   - Special (b==0): res <= op_rem ? a : all-ones; go DONE.
//   - Special (op_signed & a==0x80000000 & b==all-ones): res <= op_rem ? 0 : a; go DONE.
//   - Hit (CACHE_EN & cache_vld & {a,b,signed}==tag): res <= op_rem ? c_rem : c_quo; go DONE.
//   - Otherwise: latch a/b/signed/rem into request regs; go REQ.
//   - Special cases take priority over a cache hit.
//  REQ: div_req_valid = ~flush.
//   - flush -> IDLE; no request is issued.
//   - div_req_ready -> WAIT.
//   - Request fields remain stable until accepted.
//  WAIT:
//   - div_resp_valid -> tag <= {a,b,signed}, c_quo/c_rem <= resp, cache_vld <= 1;
//     res <= selected field; go DONE.
//   - flush (no resp this cycle) -> DRAIN.
//   - flush and resp in the same cycle -> cache is updated, result is dropped, go IDLE.
//  DRAIN: wait for div_resp_valid, discard the result, leave cache unchanged, go IDLE.
//  DONE: res_valid=1 for exactly one cycle; go IDLE. The current op retires this cycle.
//   - op_valid is not evaluated in DONE.
//   - flush in DONE does not suppress res_valid; the pipeline discards it.
//  stall = op_valid & ~flush & (state==IDLE | REQ | WAIT | DRAIN); stall=0 in DONE.
//  Latency from op_valid in IDLE to res_valid:
//   - special or hit: 1 cycle (op occupies 2 cycles);
//   - divider path: 2 + request wait + divider latency.
//  Cache has a single entry; it is invalidated only by reset. Tag includes signedness, so DIVU never
//  hits a DIV entry.
//  Reset mid-operation: the FSM returns to IDLE at once. The divider is reset by the same rst_n,
//  so no stale response can occur.
//  div_resp_valid in IDLE/REQ/DONE is a protocol error: ignore it; the bench flags it.
// TESTING
//  1 DIVU a=100 b=7 -> one div_req (a=100,b=7,signed=0); resp 14/2 -> res_valid, res=14.
//  2 Then REMU a=100 b=7 -> no div_req_valid; res=2 one cycle after op_valid.
//    Then REM a=100 b=7 -> miss (signed tag) -> divider used.
//  3 DIV a=5 b=0 -> res=0xFFFFFFFF; REM a=5 b=0 -> res=5.
//    DIV a=0x80000000 b=0xFFFFFFFF -> res=0x80000000; REM -> 0. No div_req for any of these.
//  4 div_req_ready held 0 for 5 cycles -> stall=1 throughout; div_req_a/b/signed stable; no res_valid.
//  5 flush in WAIT -> DRAIN; resp 3 cycles later -> no res_valid; cache unchanged.
//    Next op DIVU 9/3 (new operands) -> fresh request, res=3.
//  6 rst_n low during WAIT -> state IDLE, res_valid=0, div_req_valid=0, cache_vld=0.
//    Same op after reset -> divider path, not a cache hit.

Source files
------------

// File: rtl/nanorv32_divseq.sv
// -----------------------------------------------------------------------------
// nanorv32_divseq
//
// Sequencer between the execute stage and the iterative divider. It accepts
// DIV/DIVU/REM/REMU ops, drives the divider request/response handshake and
// holds the pipeline while an op is in flight.
//
// Divide-by-zero and signed overflow are resolved locally in one cycle.
// A single-entry cache keeps the last quotient/remainder pair, so a DIV
// followed by a REM on the same operands does not use the divider again.
// A pipeline flush aborts the current op cleanly.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   op_valid          divide-class op present at execute (held while stall=1)
//   op_signed         1: DIV/REM, 0: DIVU/REMU
//   op_rem            1: remainder result, 0: quotient result
//   op_a, op_b        dividend / divisor
//   flush             pipeline flush, kills the current op
//   stall             hold pipeline (combinational)
//   res_valid, res    one-cycle registered result strobe and result
//   div_req_*         request channel to the divider (fields registered)
//   div_resp_*        response channel from the divider
// -----------------------------------------------------------------------------
module nanorv32_divseq #(
   parameter int DATA_W   = 32,
   parameter bit CACHE_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   input  logic              op_signed,
   input  logic              op_rem,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              flush,
   output logic              stall,
   output logic              res_valid,
   output logic [DATA_W-1:0] res,
   output logic              div_req_valid,
   input  logic              div_req_ready,
   output logic              div_req_signed,
   output logic [DATA_W-1:0] div_req_a,
   output logic [DATA_W-1:0] div_req_b,
   input  logic              div_resp_valid,
   input  logic [DATA_W-1:0] div_resp_quo,
   input  logic [DATA_W-1:0] div_resp_rem
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   localparam logic signed [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] MINUS_1  = '1;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // Signed overflow: most negative value divided by -1.
   function automatic logic is_signed_ovf(input logic sgn,
                                          input logic signed [DATA_W-1:0] a,
                                          input logic signed [DATA_W-1:0] b);
      return sgn && (a == MIN_NEG) && (b == MINUS_1);
   endfunction

   // Architected results for the two special cases. Divide-by-zero yields
   // all-ones / dividend; overflow yields dividend / zero.
   function automatic logic [DATA_W-1:0] special_result(input logic          rem,
                                                        input logic          div_zero,
                                                        input logic [DATA_W-1:0] a);
      if (div_zero)
         return rem ? a : {DATA_W{1'b1}};
      else
         return rem ? {DATA_W{1'b0}} : a;
   endfunction

   function automatic logic [DATA_W-1:0] select_result(input logic          rem,
                                                       input logic [DATA_W-1:0] quo,
                                                       input logic [DATA_W-1:0] rmd);
      return rem ? rmd : quo;
   endfunction

   // ---------------------------------------------------------------------------
   // State and storage
   // ---------------------------------------------------------------------------
   state_t state, next_state;

   logic              req_signed;
   logic              req_rem;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;

   logic              cache_vld;
   logic [DATA_W-1:0] tag_a;
   logic [DATA_W-1:0] tag_b;
   logic              tag_signed;
   logic [DATA_W-1:0] c_quo;
   logic [DATA_W-1:0] c_rem;

   // ---------------------------------------------------------------------------
   // Op classification (only meaningful while IDLE)
   // ---------------------------------------------------------------------------
   logic accept;
   logic div_zero;
   logic sovf;
   logic special;
   logic hit;
   logic miss;
   logic resp_in_wait;

   assign accept   = (state == S_IDLE) && op_valid && !flush;
   assign div_zero = (op_b == '0);
   assign sovf     = is_signed_ovf(op_signed, op_a, op_b);
   assign special  = div_zero || sovf;
   assign hit      = CACHE_EN && cache_vld &&
                     (op_a == tag_a) && (op_b == tag_b) && (op_signed == tag_signed);
   // Special cases win over a cache hit.
   assign miss     = accept && !special && !hit;

   // The cache captures every response seen in WAIT, even one that arrives
   // with a flush: the operands were valid, only the result is unwanted.
   assign resp_in_wait = (state == S_WAIT) && div_resp_valid;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (special || hit)
                  next_state = S_DONE;
               else
                  next_state = S_REQ;
            end
         end
         S_REQ: begin
            if (flush)
               next_state = S_IDLE;
            else if (div_req_ready)
               next_state = S_WAIT;
         end
         S_WAIT: begin
            if (div_resp_valid)
               next_state = flush ? S_IDLE : S_DONE;
            else if (flush)
               next_state = S_DRAIN;
         end
         S_DONE: begin
            // op_valid is deliberately not looked at: the op retires here.
            next_state = S_IDLE;
         end
         S_DRAIN: begin
            if (div_resp_valid)
               next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: combinational outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      stall         = 1'b0;
      div_req_valid = 1'b0;
      unique case (state)
         S_IDLE, S_WAIT, S_DRAIN: stall = op_valid && !flush;
         S_REQ: begin
            stall         = op_valid && !flush;
            div_req_valid = !flush;
         end
         S_DONE:  stall = 1'b0;
         default: stall = 1'b0;
      endcase
   end

   assign div_req_signed = req_signed;
   assign div_req_a      = req_a;
   assign div_req_b      = req_b;

   // ---------------------------------------------------------------------------
   // Result register and result strobe
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res       <= '0;
      end else begin
         res_valid <= (next_state == S_DONE);
         if (accept && special)
            res <= special_result(op_rem, div_zero, op_a);
         else if (accept && hit)
            res <= select_result(op_rem, c_quo, c_rem);
         else if (resp_in_wait && !flush)
            res <= select_result(req_rem, div_resp_quo, div_resp_rem);
      end
   end

   // ---------------------------------------------------------------------------
   // Request registers: loaded on a miss, stable until the divider accepts
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_signed <= 1'b0;
         req_rem    <= 1'b0;
         req_a      <= '0;
         req_b      <= '0;
      end else if (miss) begin
         req_signed <= op_signed;
         req_rem    <= op_rem;
         req_a      <= op_a;
         req_b      <= op_b;
      end
   end

   // ---------------------------------------------------------------------------
   // Cache: valid bit is cleared only by reset
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cache_vld <= 1'b0;
      else if (resp_in_wait)
         cache_vld <= 1'b1;
   end

   // Cache payload is qualified by cache_vld, so it needs no reset.
   always_ff @(posedge clk) begin
      if (resp_in_wait) begin
         tag_a      <= req_a;
         tag_b      <= req_b;
         tag_signed <= req_signed;
         c_quo      <= div_resp_quo;
         c_rem      <= div_resp_rem;
      end
   end

endmodule

// File: tb/tb_nanorv32_divseq.sv
module tb_nanorv32_divseq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         op_valid, op_signed, op_rem;
   logic [W-1:0] op_a, op_b;
   logic         flush;
   logic         stall;
   logic         res_valid;
   logic [W-1:0] res;
   logic         div_req_valid, div_req_ready, div_req_signed;
   logic [W-1:0] div_req_a, div_req_b;
   logic         div_resp_valid;
   logic [W-1:0] div_resp_quo, div_resp_rem;

   int tests = 0;
   int fails = 0;
   logic [W-1:0] exp_q[$];

   nanorv32_divseq #(.DATA_W(W), .CACHE_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid), .op_signed(op_signed), .op_rem(op_rem),
      .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall),
      .res_valid(res_valid), .res(res),
      .div_req_valid(div_req_valid), .div_req_ready(div_req_ready),
      .div_req_signed(div_req_signed), .div_req_a(div_req_a), .div_req_b(div_req_b),
      .div_resp_valid(div_resp_valid), .div_resp_quo(div_resp_quo),
      .div_resp_rem(div_resp_rem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every result strobe pops one expected value.
   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: res_valid with res=0x%08h, none expected", res);
         end else begin
            chk("sb_res", res, exp_q.pop_front());
         end
      end
   end

   task automatic drive_op(input logic sgn, input logic rem,
                           input logic [W-1:0] a, input logic [W-1:0] b);
      op_valid  = 1'b1;
      op_signed = sgn;
      op_rem    = rem;
      op_a      = a;
      op_b      = b;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_req(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      chk("req_valid", div_req_valid, 1'b1);
      chk("req_a", div_req_a, a);
      chk("req_b", div_req_b, b);
      chk("req_signed", div_req_signed, sgn);
      chk("req_stall", stall, 1'b1);
      chk("req_no_res", res_valid, 1'b0);
   endtask

   // Op expected to go through the divider.
   task automatic run_div(input logic sgn, input logic rem,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input int rdy_wait, input int lat, input logic [W-1:0] exp);
      drive_op(sgn, rem, a, b);
      exp_q.push_back(exp);
      @(negedge clk);
      chk("idle_stall", stall, 1'b1);
      chk("idle_no_req", div_req_valid, 1'b0);
      next_cycle();
      for (int i = 0; i < rdy_wait; i++) begin
         @(negedge clk);
         chk_req(sgn, a, b);
         next_cycle();
      end
      div_req_ready = 1'b1;
      @(negedge clk);
      chk_req(sgn, a, b);
      next_cycle();
      div_req_ready = 1'b0;
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         chk("wait_stall", stall, 1'b1);
         chk("wait_no_req", div_req_valid, 1'b0);
         next_cycle();
      end
      div_resp_valid = 1'b1;
      div_resp_quo   = q;
      div_resp_rem   = r;
      next_cycle();
      div_resp_valid = 1'b0;
      @(negedge clk);
      chk("done_res_valid", res_valid, 1'b1);
      chk("done_stall", stall, 1'b0);
      next_cycle();
      op_valid = 1'b0;
   endtask

   // Op expected to resolve locally (special case or cache hit).
   task automatic run_fast(input logic sgn, input logic rem,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp);
      drive_op(sgn, rem, a, b);
      exp_q.push_back(exp);
      @(negedge clk);
      chk("fast_stall", stall, 1'b1);
      chk("fast_no_req", div_req_valid, 1'b0);
      next_cycle();
      @(negedge clk);
      chk("fast_res_valid", res_valid, 1'b1);
      chk("fast_done_stall", stall, 1'b0);
      chk("fast_no_req2", div_req_valid, 1'b0);
      next_cycle();
      op_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t expected below 200000", $time);
      $fatal(1);
   end

   initial begin
      rst_n          = 1'b0;
      op_valid       = 1'b0;
      op_signed      = 1'b0;
      op_rem         = 1'b0;
      op_a           = '0;
      op_b           = '0;
      flush          = 1'b0;
      div_req_ready  = 1'b0;
      div_resp_valid = 1'b0;
      div_resp_quo   = '0;
      div_resp_rem   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res", res, '0);
      chk("rst_req_valid", div_req_valid, 1'b0);
      chk("rst_req_a", div_req_a, '0);
      chk("rst_req_b", div_req_b, '0);
      chk("rst_stall", stall, 1'b0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // DIVU 100/7 via divider, then REMU hit, then signed REM misses.
      run_div(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 2, 32'd14);
      run_fast(1'b0, 1'b1, 32'd100, 32'd7, 32'd2);
      run_div(1'b1, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1, 1, 32'd2);

      // Special cases.
      run_fast(1'b1, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run_fast(1'b1, 1'b1, 32'd5, 32'd0, 32'd5);
      run_fast(1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run_fast(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_fast(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

      // Request not accepted for 5 cycles.
      run_div(1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 5, 3, 32'd100);

      // Flush while in REQ: no request may be issued.
      drive_op(1'b0, 1'b0, 32'd20, 32'd4);
      @(negedge clk);
      next_cycle();
      flush = 1'b1;
      @(negedge clk);
      chk("req_flush_no_req", div_req_valid, 1'b0);
      chk("req_flush_stall", stall, 1'b0);
      next_cycle();
      flush    = 1'b0;
      op_valid = 1'b0;
      @(negedge clk);
      chk("req_flush_idle_no_req", div_req_valid, 1'b0);
      next_cycle();

      // Flush in WAIT: drained response must not produce a result.
      drive_op(1'b0, 1'b0, 32'd50, 32'd5);
      @(negedge clk);
      next_cycle();
      div_req_ready = 1'b1;
      next_cycle();
      div_req_ready = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      chk("wait_flush_stall", stall, 1'b0);
      next_cycle();
      flush    = 1'b0;
      op_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("drain_no_res", res_valid, 1'b0);
         chk("drain_no_req", div_req_valid, 1'b0);
         next_cycle();
      end
      div_resp_valid = 1'b1;
      div_resp_quo   = 32'd10;
      div_resp_rem   = 32'd0;
      next_cycle();
      div_resp_valid = 1'b0;
      @(negedge clk);
      chk("drain_end_no_res", res_valid, 1'b0);
      next_cycle();
      // Cache still holds 1000/10 unsigned.
      run_fast(1'b0, 1'b1, 32'd1000, 32'd10, 32'd0);
      run_div(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 1, 32'd3);

      // Flush and response together: result dropped, cache updated.
      drive_op(1'b0, 1'b0, 32'd77, 32'd7);
      @(negedge clk);
      next_cycle();
      div_req_ready = 1'b1;
      next_cycle();
      div_req_ready  = 1'b0;
      flush          = 1'b1;
      div_resp_valid = 1'b1;
      div_resp_quo   = 32'd11;
      div_resp_rem   = 32'd0;
      next_cycle();
      flush          = 1'b0;
      div_resp_valid = 1'b0;
      op_valid       = 1'b0;
      @(negedge clk);
      chk("flush_resp_no_res", res_valid, 1'b0);
      next_cycle();
      run_fast(1'b0, 1'b1, 32'd77, 32'd7, 32'd0);
      run_fast(1'b0, 1'b0, 32'd77, 32'd7, 32'd11);

      // Fill cache with 9/3, then reset during WAIT of another op.
      run_div(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 1, 32'd3);
      drive_op(1'b0, 1'b0, 32'd64, 32'd8);
      @(negedge clk);
      next_cycle();
      div_req_ready = 1'b1;
      next_cycle();
      div_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_res_valid", res_valid, 1'b0);
      chk("midrst_req_valid", div_req_valid, 1'b0);
      chk("midrst_req_a", div_req_a, '0);
      op_valid = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      // Cache was invalidated: same op as before must use the divider.
      run_div(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 1, 32'd3);

      repeat (3) next_cycle();
      chk("sb_empty", exp_q.size(), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
